// File: rtl/dmem_lsu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_lsu : RV32 load/store unit in front of the wsync_mem data SRAM
// Rev 1.0
// ---------------------------------------------------------------------------
module dmem_lsu #(
  parameter int          MEM_SIZE  = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  localparam int         ADDR_W    = $clog2(MEM_SIZE / 4)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [2:0]        funct3_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              ready_o,
  output logic              err_o,
  output logic              busy_o,
  output logic              mem_we_o,
  output logic              mem_re_o,
  output logic [3:0]        mem_ble_o,
  output logic [31:0]       mem_d_o,
  output logic [ADDR_W-1:0] mem_add_o,
  input  logic [31:0]       mem_d_i,
  input  logic              mem_valid_i
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2,
    S_ERR    = 2'd3
  } state_t;

  localparam logic [32:0]       LIMIT   = {1'b0, BASE_ADDR} + 33'(MEM_SIZE);
  localparam logic [ADDR_W+1:0] BASE_LO = BASE_ADDR[ADDR_W+1:0];

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [2:0]          f3_q, f3_d;
  logic [ADDR_W+1:0]   off_q, off_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;

  logic                legal_f3, aligned, in_range, req_ok;
  logic [1:0]          lane;
  logic [3:0]          ble;
  logic [31:0]         store_d;
  logic [31:0]         shifted;
  logic [31:0]         load_ext;

  // Request checks act on the live inputs; only the accepting IDLE cycle uses them.
  always_comb begin
    legal_f3 = 1'b0;
    aligned  = 1'b1;
    if (we_i) legal_f3 = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010);
    else      legal_f3 = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                         (funct3_i == 3'b100) || (funct3_i == 3'b101);
    if (funct3_i[1:0] == 2'b01)      aligned = (addr_i[0] == 1'b0);
    else if (funct3_i[1:0] == 2'b10) aligned = (addr_i[1:0] == 2'b00);
    in_range = ({1'b0, addr_i} >= {1'b0, BASE_ADDR}) && ({1'b0, addr_i} < LIMIT);
    req_ok   = legal_f3 && aligned && in_range;
  end

  assign lane = off_q[1:0];

  always_comb begin
    ble     = 4'b1111;
    store_d = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        ble     = 4'b0001 << lane;
        store_d = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        ble     = lane[1] ? 4'b1100 : 4'b0011;
        store_d = {2{wdata_q[15:0]}};
      end
      default: begin
        ble     = 4'b1111;
        store_d = wdata_q;
      end
    endcase
  end

  always_comb begin
    shifted = mem_d_i >> {lane, 3'b000};
    case (f3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {24'd0, shifted[7:0]};
      3'b101:  load_ext = {16'd0, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      off_q   <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    f3_d      = f3_q;
    off_d     = off_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    rdata_o   = 32'd0;
    ready_o   = 1'b0;
    err_o     = 1'b0;
    busy_o    = 1'b0;
    mem_we_o  = 1'b0;
    mem_re_o  = 1'b0;
    mem_ble_o = 4'b0000;
    mem_d_o   = 32'd0;
    mem_add_o = '0;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          we_d    = we_i;
          f3_d    = funct3_i;
          off_d   = addr_i[ADDR_W+1:0] - BASE_LO;
          wdata_d = wdata_i;
          rdata_d = 32'd0;
          state_d = req_ok ? S_ACCESS : S_ERR;
        end
      end
      S_ACCESS: begin
        busy_o    = 1'b1;
        mem_re_o  = ~we_q;
        mem_we_o  = we_q;
        mem_ble_o = ble;
        mem_d_o   = store_d;
        mem_add_o = off_q[ADDR_W+1:2];
        if (mem_valid_i) begin
          rdata_d = we_q ? 32'd0 : load_ext;
          state_d = S_RESP;
        end
      end
      // Strobes stay low here so the SRAM wait counter restarts cleanly.
      S_RESP: begin
        busy_o  = 1'b1;
        ready_o = 1'b1;
        rdata_o = rdata_q;
        state_d = S_IDLE;
      end
      S_ERR: begin
        busy_o  = 1'b1;
        ready_o = 1'b1;
        err_o   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu.sv
`default_nettype none
// tb_dmem_lsu : directed scoreboard bench for dmem_lsu with a wsync_mem model.
module tb_dmem_lsu;

  localparam int MEM_SIZE = 4096;
  localparam int ADDR_W   = 10;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              req_i;
  logic              we_i;
  logic [2:0]        funct3_i;
  logic [31:0]       addr_i;
  logic [31:0]       wdata_i;
  logic [31:0]       rdata_o;
  logic              ready_o;
  logic              err_o;
  logic              busy_o;
  logic              mem_we_o;
  logic              mem_re_o;
  logic [3:0]        mem_ble_o;
  logic [31:0]       mem_d_o;
  logic [ADDR_W-1:0] mem_add_o;
  logic [31:0]       mem_d_i;
  logic              mem_valid_i;

  dmem_lsu #(.MEM_SIZE(MEM_SIZE), .BASE_ADDR(32'h0000_0000)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .funct3_i(funct3_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .ready_o(ready_o),
    .err_o(err_o), .busy_o(busy_o), .mem_we_o(mem_we_o), .mem_re_o(mem_re_o),
    .mem_ble_o(mem_ble_o), .mem_d_o(mem_d_o), .mem_add_o(mem_add_o),
    .mem_d_i(mem_d_i), .mem_valid_i(mem_valid_i)
  );

  always #5 clk_i = ~clk_i;

  // SRAM model: valid after ws wait states while a strobe is held, read data masked by ble.
  int          ws = 0;
  int          cnt = 0;
  logic [31:0] mem [0:MEM_SIZE/4-1];
  logic [31:0] ble_mask;

  assign ble_mask    = {{8{mem_ble_o[3]}}, {8{mem_ble_o[2]}}, {8{mem_ble_o[1]}}, {8{mem_ble_o[0]}}};
  assign mem_valid_i = (mem_re_o | mem_we_o) && (cnt == ws);
  assign mem_d_i     = mem_re_o ? (mem[mem_add_o] & ble_mask) : 32'd0;

  always @(posedge clk_i) begin
    if (!(mem_re_o | mem_we_o)) cnt <= 0;
    else if (cnt != ws)         cnt <= cnt + 1;
    if (mem_we_o && mem_valid_i)
      mem[mem_add_o] <= (mem[mem_add_o] & ~ble_mask) | (mem_d_o & ble_mask);
  end

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          strobes;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  logic [3:0]        ble_s;
  logic [ADDR_W-1:0] add_s;
  logic [31:0]       d_s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic access(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] erd, input logic eerr);
    exp_t e;
    int   n = 0;
    int   strb = 0;
    logic done = 1'b0;
    logic resp_strobe = 1'b0;
    logic [31:0] rd = 32'd0;
    logic er = 1'b0;
    e.rd = erd; e.err = eerr;
    e.lat = eerr ? 1 : ws + 2;
    e.strobes = eerr ? 0 : ws + 1;
    sb.push_back(e);
    @(negedge clk_i);
    req_i = 1'b1; we_i = we; funct3_i = f3; addr_i = a; wdata_i = wd;
    while (!done && n < 40) begin
      @(posedge clk_i);
      n++;
      @(negedge clk_i);
      if (mem_re_o | mem_we_o) begin
        strb++;
        ble_s = mem_ble_o; add_s = mem_add_o; d_s = mem_d_o;
      end
      if (ready_o) begin
        done = 1'b1;
        rd = rdata_o; er = err_o;
        resp_strobe = mem_re_o | mem_we_o;
        req_i = 1'b0;
      end
    end
    req_i = 1'b0;
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    e = sb.pop_front();
    chk({tag, "_rdata"}, rd, e.rd);
    chk({tag, "_err"}, {31'd0, er}, {31'd0, e.err});
    chk({tag, "_lat"}, 32'(n), 32'(e.lat));
    chk({tag, "_strobes"}, 32'(strb), 32'(e.strobes));
    chk({tag, "_resp_strobe"}, {31'd0, resp_strobe}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < MEM_SIZE/4; i++) mem[i] = 32'd0;
    rst_ni = 1'b0; req_i = 1'b0; we_i = 1'b0; funct3_i = 3'd0; addr_i = 32'd0; wdata_i = 32'd0;
    #1;
    chk("reset_ctl", {27'd0, busy_o, ready_o, err_o, mem_re_o, mem_we_o}, 32'd0);
    chk("reset_rdata", rdata_o, 32'd0);
    chk("reset_bus", {28'd0, mem_ble_o} | 32'(mem_add_o) | mem_d_o, 32'd0);
    @(negedge clk_i); @(negedge clk_i);
    rst_ni = 1'b1;

    ws = 0;
    access("sw", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
    chk("sw_ble", {28'd0, ble_s}, 32'hF);
    chk("sw_add", 32'(add_s), 32'd4);
    chk("sw_d", d_s, 32'hDEADBEEF);
    access("lw", 1'b0, 3'b010, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);

    access("sb", 1'b1, 3'b000, 32'h13, 32'h0000_0080, 32'd0, 1'b0);
    chk("sb_ble", {28'd0, ble_s}, 32'h8);
    chk("sb_d", d_s, 32'h80808080);
    access("lb", 1'b0, 3'b000, 32'h13, 32'd0, 32'hFFFFFF80, 1'b0);
    access("lbu", 1'b0, 3'b100, 32'h13, 32'd0, 32'h00000080, 1'b0);

    access("lh", 1'b0, 3'b001, 32'h12, 32'd0, 32'hFFFF80AD, 1'b0);
    chk("lh_ble", {28'd0, ble_s}, 32'hC);
    access("lhu", 1'b0, 3'b101, 32'h12, 32'd0, 32'h000080AD, 1'b0);

    access("sh", 1'b1, 3'b001, 32'h20, 32'h1234_5678, 32'd0, 1'b0);
    chk("sh_ble", {28'd0, ble_s}, 32'h3);
    chk("sh_d", d_s, 32'h56785678);
    access("lw_top", 1'b0, 3'b010, 32'hFFC, 32'd0, 32'd0, 1'b0);
    chk("lw_top_add", 32'(add_s), 32'h3FF);

    ws = 3;
    access("lw_ws3", 1'b0, 3'b010, 32'h10, 32'd0, 32'h80ADBEEF, 1'b0);

    ws = 0;
    access("err_lw_mis", 1'b0, 3'b010, 32'h2, 32'd0, 32'd0, 1'b1);
    access("err_lh_mis", 1'b0, 3'b001, 32'h1, 32'd0, 32'd0, 1'b1);
    access("err_range", 1'b0, 3'b010, 32'(MEM_SIZE), 32'd0, 32'd0, 1'b1);
    access("err_f3", 1'b0, 3'b011, 32'h0, 32'd0, 32'd0, 1'b1);
    access("err_sbu", 1'b1, 3'b100, 32'h0, 32'd0, 32'd0, 1'b1);
    access("err_wrap", 1'b0, 3'b010, 32'hFFFF_FFFC, 32'd0, 32'd0, 1'b1);

    ws = 3;
    @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h10;
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    chk("rst_mid_pre", {31'd0, mem_re_o}, 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("rst_mid_ctl", {27'd0, busy_o, ready_o, err_o, mem_re_o, mem_we_o}, 32'd0);
    chk("rst_mid_rdata", rdata_o, 32'd0);
    chk("rst_mid_bus", {28'd0, mem_ble_o} | 32'(mem_add_o) | mem_d_o, 32'd0);
    req_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    access("lw_after_rst", 1'b0, 3'b010, 32'h10, 32'd0, 32'h80ADBEEF, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
